// File: rtl/dmem_responder_if.sv
// Bus bundle between the L1 D-cache port (master) and the memory-side responder (slave),
// including the responder's SRAM macro pins.
interface dmem_responder_if #(
  parameter int ADDR_W = 14
);
  logic              D_req;
  logic [31:0]       D_addr;
  logic              D_write;
  logic [31:0]       D_in;
  logic [2:0]        D_type;
  logic [31:0]       D_out;
  logic              D_wait;
  logic              D_err;
  logic              mem_cs;
  logic              mem_oe;
  logic [3:0]        mem_web;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_di;
  logic [31:0]       mem_do;

  modport master (
    output D_req, D_addr, D_write, D_in, D_type,
    input  D_out, D_wait, D_err
  );

  modport slave (
    input  D_req, D_addr, D_write, D_in, D_type,
    output D_out, D_wait, D_err,
    output mem_cs, mem_oe, mem_web, mem_a, mem_di,
    input  mem_do
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding D-port responder driving a synchronous single-port SRAM.
// Optional misalignment checking is enabled by defining DMEM_RESP_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 14
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] a_q;
  logic [31:0]       di_q;
  logic [31:0]       hold_q;
  logic              suppress;

  // Request decode: 0/4 byte, 1/5 half, everything else word.
  logic        is_byte, is_half;
  logic [3:0]  be_n;
  logic [31:0] di_n;

  assign is_byte = (bus.D_type == 3'd0) || (bus.D_type == 3'd4);
  assign is_half = (bus.D_type == 3'd1) || (bus.D_type == 3'd5);

  always_comb begin
    if (is_byte) begin
      be_n = 4'b0001 << bus.D_addr[1:0];
      di_n = {4{bus.D_in[7:0]}};
    end else if (is_half) begin
      be_n = bus.D_addr[1] ? 4'b1100 : 4'b0011;
      di_n = {2{bus.D_in[15:0]}};
    end else begin
      be_n = 4'b1111;
      di_n = bus.D_in;
    end
  end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  logic mis_q;
  logic mis_n;
  assign mis_n = is_byte ? 1'b0 :
                 is_half ? bus.D_addr[0] : (bus.D_addr[1:0] != 2'b00);
  assign suppress   = mis_q;
  assign bus.D_err  = !rst && (state_q == RESP) && mis_q;

  always_ff @(posedge clk) begin
    if (rst)                              mis_q <= 1'b0;
    else if (state_q == IDLE && bus.D_req) mis_q <= mis_n;
  end
`else
  assign suppress  = 1'b0;
  assign bus.D_err = 1'b0;
`endif

  assign bus.mem_a  = a_q;
  assign bus.mem_di = di_q;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    bus.D_wait  = 1'b1;
    bus.D_out   = hold_q;
    bus.mem_cs  = 1'b0;
    bus.mem_oe  = 1'b0;
    bus.mem_web = 4'hF;
    case (state_q)
      IDLE: begin
        bus.D_wait = bus.D_req;
        if (bus.D_req) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          bus.mem_cs = 1'b1;
          if (wr_q) bus.mem_web = suppress ? 4'hF : ~be_q;
          else      bus.mem_oe  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.D_wait = 1'b0;
        if (!wr_q) bus.D_out = suppress ? 32'h0 : bus.mem_do;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything: busy, no strobe, no response.
    if (rst) begin
      bus.D_wait  = 1'b1;
      bus.D_out   = hold_q;
      bus.mem_cs  = 1'b0;
      bus.mem_oe  = 1'b0;
      bus.mem_web = 4'hF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      a_q     <= '0;
      di_q    <= 32'h0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.D_req) begin
          wr_q  <= bus.D_write;
          be_q  <= be_n;
          a_q   <= bus.D_addr[ADDR_W+1:2];
          di_q  <= di_n;
          cnt_q <= 4'(WAIT_CYCLES);
        end
        ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        RESP:   if (!wr_q && !suppress) hold_q <= bus.mem_do;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the L1 data cache's D-port: accepts a single outstanding cache request (D_req/D_addr/D_write/D_in/D_type), holds D_wait high while it performs the access on a synchronous single-port SRAM macro, then returns read data on D_out. It sits inside the CPU wrapper between the data cache and the data SRAM. It also generates byte write enables from D_type and performs lane replication.

## Interface
- WAIT_CYCLES, 1, extra ACCESS cycles before the SRAM strobe (legal 0..15)
- ADDR_W, 14, SRAM word-address width (mem_a = D_addr[ADDR_W+1:2])

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- D_req  in  1  request valid
- D_addr  in  32  byte address
- D_write  in  1  1 = write, 0 = read
- D_in  in  32  write data (LSB-justified for sub-word)
- D_type  in  3  access type: 0 byte, 1 half, 2 word, 4 byte-unsigned, 5 half-unsigned; 3/6/7 treated as word
- D_out  out  32  read word (full aligned word, no extraction)
- D_wait  out  1  responder busy
- D_err  out  1  misaligned-access flag (see Configuration)
- mem_cs  out  1  SRAM chip select
- mem_oe  out  1  SRAM output enable
- mem_web  out  4  SRAM byte write enables, active-low
- mem_a  out  ADDR_W  SRAM word address
- mem_di  out  32  SRAM write data
- mem_do  in  32  SRAM read data, valid the cycle after the strobe

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: D_wait = D_req (combinational). On D_req=1: latch write, type, mem_a, mem_di, byte-enables; load counter = WAIT_CYCLES; -> ACCESS.
- ACCESS: D_wait=1. Counter decrements each cycle; when counter==0 drive strobe this cycle: mem_cs=1; read: mem_oe=1, mem_web=4'hF; write: mem_oe=0, mem_web=~be. -> RESP.
- RESP: D_wait=0 for exactly one cycle; read: D_out = mem_do, hold register loads mem_do; write: D_out = hold register. -> IDLE unconditionally (a D_req in RESP is not accepted until the next IDLE cycle).
- Byte enables: byte -> bit D_addr[1:0]; half -> 4'b0011 if D_addr[1]=0 else 4'b1100; word -> 4'b1111.
- Lane data: byte -> {4{D_in[7:0]}}; half -> {2{D_in[15:0]}}; word -> D_in.
- D_req, D_addr, D_in changes while not IDLE are ignored; the latched transaction completes.
- Outside strobe cycle: mem_cs=0, mem_oe=0, mem_web=4'hF. mem_a/mem_di hold last latched value.
- D_out holds the last returned read word outside RESP.

## Timing
- Request accepted at cycle T (IDLE, D_req=1, D_wait=1).
- Strobe at T+1+WAIT_CYCLES; RESP (D_wait=0, D_out valid) at T+2+WAIT_CYCLES; next accept earliest T+3+WAIT_CYCLES.
- WAIT_CYCLES=0: strobe T+1, RESP T+2.
- Reset values (after rising edge with rst=1): state IDLE, D_out 0, D_err 0, mem_a 0, mem_di 0, counter 0; mem_cs=0, mem_oe=0, mem_web=4'hF. While rst=1, D_wait=1 and no strobe is driven.
- Reset mid-ACCESS or in RESP: transaction abandoned, no strobe or response, IDLE next cycle.

## Configuration
- DMEM_RESP_ALIGN_CHECK_EN defined: misaligned request (half with D_addr[0]=1, word/reserved with D_addr[1:0]!=0) still runs the full latency. D_err=1 only in RESP. Writes are suppressed (mem_web stays 4'hF, mem_cs still pulses). Reads return D_out=0 and do not update the hold register.
- Undefined: D_err tied 0; low address bits ignored beyond the byte-enable rules; accesses proceed normally.

## Test plan
- Word write 0xDEADBEEF to 0x0000_0010, WAIT_CYCLES=1 -> strobe at T+2 with mem_a=4, mem_web=4'b0000; D_wait low only at T+3. Then read 0x10 -> D_out=0xDEADBEEF in RESP.
- Byte write 0xA5 to 0x13 over 0x11223344 -> mem_web=4'b0111, mem_di=0xA5A5A5A5. Read back word -> 0xA5223344.
- Half write 0xBEEF to 0x22 -> mem_web=4'b0011, mem_di=0xBEEFBEEF.
- Back-to-back: D_req held high through RESP -> second accept one cycle after RESP, exactly one strobe per transaction. D_addr change mid-ACCESS -> original address used.
- rst=1 during ACCESS of a write -> no mem_cs pulse, D_wait=1 during reset, D_out=0, IDLE after.
- With DMEM_RESP_ALIGN_CHECK_EN: word write to 0x02 -> D_err=1 in RESP, mem_web stays 4'hF, memory unchanged. Without macro: D_err=0 and the write lands at word 0.
